// File: rtl/dbg_pkg.sv
// Shared command codes, FSM state type, response words and decode helpers
// for the core-side debug responder.
package dbg_pkg;

  localparam logic [7:0] DBG_CMD_NONE   = 8'h00;
  localparam logic [7:0] DBG_CMD_HALT   = 8'h01;
  localparam logic [7:0] DBG_CMD_RESUME = 8'h02;
  localparam logic [7:0] DBG_CMD_RD_REG = 8'h03;
  localparam logic [7:0] DBG_CMD_WR_REG = 8'h04;
  localparam logic [7:0] DBG_CMD_RD_PC  = 8'h05;
  localparam logic [7:0] DBG_CMD_WR_PC  = 8'h06;

  localparam logic [31:0] DBG_RESP_REJECT  = 32'h0BAD_C0DE;
  localparam logic [31:0] DBG_RESP_TIMEOUT = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_HALT_WAIT = 3'd1,
    ST_RF_RD     = 3'd2,
    ST_EXEC      = 3'd3,
    ST_DONE      = 3'd4
  } dbg_state_e;

  // True for every command code the responder acts on (00 and unknown codes are ignored).
  function automatic logic dbg_cmd_valid(input logic [7:0] cmd);
    return (cmd >= DBG_CMD_HALT) && (cmd <= DBG_CMD_WR_PC);
  endfunction

  // Register and PC commands are only safe while the pipeline is drained.
  function automatic logic dbg_cmd_needs_halt(input logic [7:0] cmd);
    return (cmd >= DBG_CMD_RD_REG) && (cmd <= DBG_CMD_WR_PC);
  endfunction

endpackage

// File: rtl/core_dbg_responder_if.sv
// Debug command bus between the debug module (master) and the core (slave).
interface core_dbg_responder_if;

  logic [7:0]  cmd;
  logic [31:0] addr;
  logic [31:0] data_dbg_dut;
  logic [31:0] data_dut_dbg;
  logic        dut_done;

  modport master (
    output cmd,
    output addr,
    output data_dbg_dut,
    input  data_dut_dbg,
    input  dut_done
  );

  modport slave (
    input  cmd,
    input  addr,
    input  data_dbg_dut,
    output data_dut_dbg,
    output dut_done
  );

endinterface

// File: rtl/core_dbg_responder.sv
// Core-side debug responder: latches a debug command, executes it against the
// pipeline / regfile / IF PC and answers with response data and a done pulse.
// Every output is driven straight from a flop.
module core_dbg_responder
  import dbg_pkg::*;
#(
  parameter int HALT_TIMEOUT = 256,
  parameter int RF_LAT       = 1
) (
  input  logic                 clk,
  input  logic                 rst_i,
  core_dbg_responder_if.slave  dbg,
  output logic                 halt_req_o,
  input  logic                 halted_i,
  output logic [4:0]           rf_addr_o,
  output logic                 rf_we_o,
  output logic [31:0]          rf_wdata_o,
  input  logic [31:0]          rf_rdata_i,
  input  logic [31:0]          if_pc_i,
  output logic                 pc_we_o,
  output logic [31:0]          pc_wdata_o,
  output logic                 flush_o
);

  localparam int              CNT_W    = $clog2(HALT_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(HALT_TIMEOUT);
  localparam logic [1:0]       LAT_LIM  = 2'(RF_LAT);

  dbg_state_e       state_r,     state_s;
  logic [7:0]       cmd_r,       cmd_s;
  logic [4:0]       addr_r,      addr_s;
  logic [31:0]      data_r,      data_s;
  logic [CNT_W-1:0] cnt_r,       cnt_s;
  logic [CNT_W-1:0] cnt_inc_s;
  logic [1:0]       lat_r,       lat_s;

  logic [31:0]      dbg_data_r,  dbg_data_s;
  logic             done_r,      done_s;
  logic             halt_req_r,  halt_req_s;
  logic [4:0]       rf_addr_r,   rf_addr_s;
  logic             rf_we_r,     rf_we_s;
  logic [31:0]      rf_wdata_r,  rf_wdata_s;
  logic             pc_we_r,     pc_we_s;
  logic [31:0]      pc_wdata_r,  pc_wdata_s;
  logic             flush_r,     flush_s;

  // Only the register index part of the address is meaningful.
  logic             addr_hi_unused_s;
  assign addr_hi_unused_s = ^dbg.addr[31:5];

  assign cnt_inc_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};

  // Next-state and next-output decode; every register holds unless a state changes it.
  always_comb begin
    state_s    = state_r;
    cmd_s      = cmd_r;
    addr_s     = addr_r;
    data_s     = data_r;
    cnt_s      = cnt_r;
    lat_s      = lat_r;
    dbg_data_s = dbg_data_r;
    done_s     = 1'b0;
    halt_req_s = halt_req_r;
    rf_addr_s  = rf_addr_r;
    rf_we_s    = 1'b0;
    rf_wdata_s = rf_wdata_r;
    pc_we_s    = 1'b0;
    pc_wdata_s = pc_wdata_r;
    flush_s    = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (dbg_cmd_valid(dbg.cmd)) begin
          cmd_s  = dbg.cmd;
          addr_s = dbg.addr[4:0];
          data_s = dbg.data_dbg_dut;
          if (dbg_cmd_needs_halt(dbg.cmd) && !halted_i) begin
            // Running core: refuse without touching regfile or PC.
            dbg_data_s = DBG_RESP_REJECT;
            state_s    = ST_DONE;
          end else begin
            case (dbg.cmd)
              DBG_CMD_HALT: begin
                halt_req_s = 1'b1;
                if (halted_i) begin
                  dbg_data_s = 32'h0000_0000;
                  state_s    = ST_DONE;
                end else begin
                  cnt_s   = {CNT_W{1'b0}};
                  state_s = ST_HALT_WAIT;
                end
              end
              DBG_CMD_RESUME: begin
                halt_req_s = 1'b0;
                state_s    = ST_DONE;
              end
              DBG_CMD_RD_REG: begin
                rf_addr_s = dbg.addr[4:0];
                lat_s     = 2'd0;
                state_s   = ST_RF_RD;
              end
              DBG_CMD_WR_REG: begin
                state_s = ST_EXEC;
              end
              DBG_CMD_RD_PC: begin
                dbg_data_s = if_pc_i;
                state_s    = ST_DONE;
              end
              DBG_CMD_WR_PC: begin
                state_s = ST_EXEC;
              end
              default: begin
                state_s = ST_IDLE;
              end
            endcase
          end
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_HALT_WAIT: begin
        if (halted_i) begin
          dbg_data_s = 32'h0000_0000;
          state_s    = ST_DONE;
        end else if (cnt_inc_s == TO_LIMIT) begin
          // Core never drained: withdraw the request so it keeps running.
          cnt_s      = cnt_inc_s;
          halt_req_s = 1'b0;
          dbg_data_s = DBG_RESP_TIMEOUT;
          state_s    = ST_DONE;
        end else begin
          cnt_s = cnt_inc_s;
        end
      end

      ST_RF_RD: begin
        // Capture and done are issued together so the read finishes in 2+RF_LAT cycles.
        if (lat_r == LAT_LIM) begin
          if (addr_r == 5'd0) begin
            dbg_data_s = 32'h0000_0000;
          end else begin
            dbg_data_s = rf_rdata_i;
          end
          done_s  = 1'b1;
          state_s = ST_IDLE;
        end else begin
          lat_s = lat_r + 2'd1;
        end
      end

      ST_EXEC: begin
        if (cmd_r == DBG_CMD_WR_REG) begin
          rf_addr_s  = addr_r;
          rf_wdata_s = data_r;
          rf_we_s    = (addr_r != 5'd0);
        end else if (cmd_r == DBG_CMD_WR_PC) begin
          pc_wdata_s = data_r;
          pc_we_s    = 1'b1;
          flush_s    = 1'b1;
        end else begin
          rf_we_s = 1'b0;
        end
        state_s = ST_DONE;
      end

      ST_DONE: begin
        done_s  = 1'b1;
        state_s = ST_IDLE;
      end

      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, latched command and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      state_r    <= ST_IDLE;
      cmd_r      <= 8'h00;
      addr_r     <= 5'd0;
      data_r     <= 32'h0000_0000;
      cnt_r      <= {CNT_W{1'b0}};
      lat_r      <= 2'd0;
      dbg_data_r <= 32'h0000_0000;
      done_r     <= 1'b0;
      halt_req_r <= 1'b0;
      rf_addr_r  <= 5'd0;
      rf_we_r    <= 1'b0;
      rf_wdata_r <= 32'h0000_0000;
      pc_we_r    <= 1'b0;
      pc_wdata_r <= 32'h0000_0000;
      flush_r    <= 1'b0;
    end else begin
      state_r    <= state_s;
      cmd_r      <= cmd_s;
      addr_r     <= addr_s;
      data_r     <= data_s;
      cnt_r      <= cnt_s;
      lat_r      <= lat_s;
      dbg_data_r <= dbg_data_s;
      done_r     <= done_s;
      halt_req_r <= halt_req_s;
      rf_addr_r  <= rf_addr_s;
      rf_we_r    <= rf_we_s;
      rf_wdata_r <= rf_wdata_s;
      pc_we_r    <= pc_we_s;
      pc_wdata_r <= pc_wdata_s;
      flush_r    <= flush_s;
    end
  end

  assign dbg.data_dut_dbg = dbg_data_r;
  assign dbg.dut_done     = done_r;
  assign halt_req_o       = halt_req_r;
  assign rf_addr_o        = rf_addr_r;
  assign rf_we_o          = rf_we_r;
  assign rf_wdata_o       = rf_wdata_r;
  assign pc_we_o          = pc_we_r;
  assign pc_wdata_o       = pc_wdata_r;
  assign flush_o          = flush_r;

endmodule

// File: tb/tb_core_dbg_responder.sv
// Directed bench for core_dbg_responder with a 1-cycle synchronous regfile stub.
module tb_core_dbg_responder;

  localparam int HALT_TIMEOUT = 256;
  localparam int RF_LAT       = 1;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        halt_req_o;
  logic        halted_i;
  logic [4:0]  rf_addr_o;
  logic        rf_we_o;
  logic [31:0] rf_wdata_o;
  logic [31:0] rf_rdata_i;
  logic [31:0] if_pc_i;
  logic        pc_we_o;
  logic [31:0] pc_wdata_o;
  logic        flush_o;

  int n_chk  = 0;
  int n_fail = 0;

  logic [4:0]  seen_rf_addr;
  logic [31:0] seen_rf_wdata;
  logic [31:0] seen_pc_wdata;
  int          lat, we_n, pc_n, fl_n, dn;

  logic [31:0] rf_mem [32];

  core_dbg_responder_if dbg_if ();

  core_dbg_responder #(
    .HALT_TIMEOUT (HALT_TIMEOUT),
    .RF_LAT       (RF_LAT)
  ) dut (
    .clk        (clk),
    .rst_i      (rst_i),
    .dbg        (dbg_if.slave),
    .halt_req_o (halt_req_o),
    .halted_i   (halted_i),
    .rf_addr_o  (rf_addr_o),
    .rf_we_o    (rf_we_o),
    .rf_wdata_o (rf_wdata_o),
    .rf_rdata_i (rf_rdata_i),
    .if_pc_i    (if_pc_i),
    .pc_we_o    (pc_we_o),
    .pc_wdata_o (pc_wdata_o),
    .flush_o    (flush_o)
  );

  always #5 clk = ~clk;

  // Regfile stub: synchronous read (one cycle), x0 deliberately holds garbage.
  always @(posedge clk) begin
    if (rst_i) begin
      for (int i = 0; i < 32; i++) rf_mem[i] <= 32'hA5A5_0000 | 32'(i);
      rf_mem[0] <= 32'hDEAD_BEEF;
    end else if (rf_we_o) begin
      rf_mem[rf_addr_o] <= rf_wdata_o;
    end
    rf_rdata_i <= rf_mem[rf_addr_o];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Present a command for one cycle, then a resume code as a distractor, then idle.
  // Returns latency (0 if no done within limit) and pulse counts seen on the way.
  task automatic run_cmd(input logic [7:0] cmd, input logic [31:0] addr,
                         input logic [31:0] data, input int halt_at, input int limit);
    lat = 0; we_n = 0; pc_n = 0; fl_n = 0;
    @(negedge clk);
    dbg_if.cmd          = cmd;
    dbg_if.addr         = addr;
    dbg_if.data_dbg_dut = data;
    for (int k = 1; k <= limit; k++) begin
      @(negedge clk);
      if (k == 1) dbg_if.cmd = 8'h02;
      if (k == 2) dbg_if.cmd = 8'h00;
      if (halt_at != 0 && k == halt_at) halted_i = 1'b1;
      if (rf_we_o) begin
        we_n++;
        seen_rf_addr  = rf_addr_o;
        seen_rf_wdata = rf_wdata_o;
      end
      if (pc_we_o) begin
        pc_n++;
        seen_pc_wdata = pc_wdata_o;
      end
      if (flush_o) fl_n++;
      if (dbg_if.dut_done) begin
        lat = k;
        break;
      end
    end
    dbg_if.cmd = 8'h00;
    @(negedge clk);
    chk("done_one_cycle", {31'd0, dbg_if.dut_done}, 32'd0);
  endtask

  // Count done pulses over n cycles.
  task automatic count_done(input int n);
    dn = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (dbg_if.dut_done) dn++;
    end
  endtask

  initial begin
    rst_i               = 1'b1;
    halted_i            = 1'b0;
    if_pc_i             = 32'h8000_0040;
    dbg_if.cmd          = 8'h00;
    dbg_if.addr         = 32'h0;
    dbg_if.data_dbg_dut = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_data",     dbg_if.data_dut_dbg, 32'h0);
    chk("rst_outs",     {26'd0, dbg_if.dut_done, halt_req_o, rf_we_o, pc_we_o, flush_o, 1'b0}, 32'h0);
    chk("rst_rf_addr",  {27'd0, rf_addr_o}, 32'h0);
    chk("rst_wdata",    rf_wdata_o | pc_wdata_o, 32'h0);
    rst_i = 1'b0;
    count_done(3);
    chk("idle_no_done", dn, 0);

    // Halt, core acknowledges in cycle 5.
    run_cmd(8'h01, 32'h0, 32'h0, 5, 40);
    chk("halt_lat",  lat, 7);
    chk("halt_data", dbg_if.data_dut_dbg, 32'h0);
    chk("halt_req",  {31'd0, halt_req_o}, 32'd1);

    // Register write then read-back of x7.
    run_cmd(8'h04, 32'h7, 32'h1234_5678, 0, 20);
    chk("wr7_lat",   lat, 3);
    chk("wr7_we",    we_n, 1);
    chk("wr7_addr",  {27'd0, seen_rf_addr}, 32'd7);
    chk("wr7_wdata", seen_rf_wdata, 32'h1234_5678);
    chk("wr7_nopc",  pc_n + fl_n, 0);
    run_cmd(8'h03, 32'hFFFF_FFE7, 32'h0, 0, 20);
    chk("rd7_lat",   lat, 2 + RF_LAT);
    chk("rd7_data",  dbg_if.data_dut_dbg, 32'h1234_5678);

    // x0: no write strobe, reads as zero regardless of stored content.
    run_cmd(8'h04, 32'h0, 32'h0000_CAFE, 0, 20);
    chk("wr0_lat",  lat, 3);
    chk("wr0_nowe", we_n, 0);
    run_cmd(8'h03, 32'h0, 32'h0, 0, 20);
    chk("rd0_lat",  lat, 2 + RF_LAT);
    chk("rd0_data", dbg_if.data_dut_dbg, 32'h0);

    // PC read.
    run_cmd(8'h05, 32'h0, 32'h0, 0, 20);
    chk("rdpc_lat",  lat, 2);
    chk("rdpc_data", dbg_if.data_dut_dbg, 32'h8000_0040);

    // Core falls out of halt: request stays up; PC write is rejected.
    halted_i = 1'b0;
    count_done(2);
    chk("halt_req_held", {31'd0, halt_req_o}, 32'd1);
    run_cmd(8'h06, 32'h0, 32'h0000_0100, 0, 20);
    chk("wrpc_rej_lat",   lat, 2);
    chk("wrpc_rej_pulse", pc_n + fl_n, 0);
    chk("wrpc_rej_data",  dbg_if.data_dut_dbg, 32'h0BAD_C0DE);
    run_cmd(8'h04, 32'h9, 32'h5555_AAAA, 0, 20);
    chk("wr_rej_nowe", we_n, 0);

    // Halted again: PC write takes effect.
    halted_i = 1'b1;
    run_cmd(8'h06, 32'h0, 32'h0000_0100, 0, 20);
    chk("wrpc_lat",   lat, 3);
    chk("wrpc_pc",    pc_n, 1);
    chk("wrpc_flush", fl_n, 1);
    chk("wrpc_wdata", seen_pc_wdata, 32'h0000_0100);

    // Resume.
    run_cmd(8'h02, 32'h0, 32'h0, 0, 20);
    chk("resume_lat", lat, 2);
    chk("resume_req", {31'd0, halt_req_o}, 32'd0);

    // Halt never acknowledged.
    halted_i = 1'b0;
    run_cmd(8'h01, 32'h0, 32'h0, 0, HALT_TIMEOUT + 40);
    chk("to_lat",  lat, HALT_TIMEOUT + 2);
    chk("to_data", dbg_if.data_dut_dbg, 32'hFFFF_FFFF);
    chk("to_req",  {31'd0, halt_req_o}, 32'd0);

    // Reset while waiting for halt.
    @(negedge clk);
    dbg_if.cmd = 8'h01;
    @(negedge clk);
    dbg_if.cmd = 8'h00;
    @(negedge clk);
    chk("hw_req_up", {31'd0, halt_req_o}, 32'd1);
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    chk("hw_rst_req",  {31'd0, halt_req_o}, 32'd0);
    chk("hw_rst_data", dbg_if.data_dut_dbg, 32'h0);
    count_done(HALT_TIMEOUT + 8);
    chk("hw_rst_nodone", dn, 0);

    // Reset while a register read is pending.
    halted_i = 1'b1;
    run_cmd(8'h05, 32'h0, 32'h0, 0, 20);
    @(negedge clk);
    dbg_if.cmd  = 8'h03;
    dbg_if.addr = 32'h5;
    @(negedge clk);
    dbg_if.cmd = 8'h00;
    chk("rr_addr_up", {27'd0, rf_addr_o}, 32'd5);
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    chk("rr_rst_addr", {27'd0, rf_addr_o}, 32'd0);
    chk("rr_rst_data", dbg_if.data_dut_dbg, 32'h0);
    chk("rr_rst_done", {31'd0, dbg_if.dut_done}, 32'd0);
    count_done(6);
    chk("rr_rst_nodone", dn, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
